power_avg: RTL and testbench

POWER_AVG -- requirements
Module: power_avg

---
 rtl/power_avg.sv | 125 ++++++++++++
 tb/tb_power_avg.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/power_avg.sv
// Streaming |x|^2 power meter for complex samples: either one result per sample
// (mode 0) or one mean per window of 2^ACC_LOG2 samples (mode 1).
module power_avg #(
   parameter int IN_W     = 8,
   parameter int ACC_LOG2 = 2   // legal range 1..8
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic signed [IN_W-1:0] real_i,
   input  logic signed [IN_W-1:0] imag_i,
   input  logic                   valid_i,
   input  logic                   mode_i,
   input  logic                   clr_i,
   output logic [2*IN_W-1:0]      res_o,
   output logic                   valid_o,
   output logic [ACC_LOG2-1:0]    cnt_o
);

   localparam int RES_W = 2 * IN_W;
   localparam int ACC_W = RES_W + ACC_LOG2;

   // S1: input capture; mode travels with its sample from here on
   logic signed [IN_W-1:0] re1_q, im1_q;
   logic                   mode1_q, vld1_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         re1_q   <= '0;
         im1_q   <= '0;
         mode1_q <= 1'b0;
         vld1_q  <= 1'b0;
      end else begin
         vld1_q <= valid_i;
         if (valid_i) begin
            re1_q   <= real_i;
            im1_q   <= imag_i;
            mode1_q <= mode_i;
         end
      end
   end

   // S2: full-precision squares; a square always fits the 2*IN_W signed product
   logic signed [RES_W-1:0] re_ext, im_ext, sq_re_d, sq_im_d;
   logic [RES_W-1:0]        sq_re_q, sq_im_q;
   logic                    mode2_q, vld2_q;

   assign re_ext  = {{IN_W{re1_q[IN_W-1]}}, re1_q};
   assign im_ext  = {{IN_W{im1_q[IN_W-1]}}, im1_q};
   assign sq_re_d = re_ext * re_ext;
   assign sq_im_d = im_ext * im_ext;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sq_re_q <= '0;
         sq_im_q <= '0;
         mode2_q <= 1'b0;
         vld2_q  <= 1'b0;
      end else begin
         vld2_q <= vld1_q;
         if (vld1_q) begin
            sq_re_q <= sq_re_d;
            sq_im_q <= sq_im_d;
            mode2_q <= mode1_q;
         end
      end
   end

   // S3: sum, window accumulation and result; the sum peaks at 2^(RES_W-1), so no overflow
   logic [RES_W-1:0]    sum_d;
   logic [ACC_W-1:0]    acc_sum;
   logic [ACC_W-1:0]    acc_q, acc_d;
   logic [ACC_LOG2-1:0] cnt_q, cnt_d;
   logic [RES_W-1:0]    res_q, res_d;
   logic                vout_q, vout_d;

   assign sum_d   = sq_re_q + sq_im_q;
   assign acc_sum = acc_q + {{ACC_LOG2{1'b0}}, sum_d};

   always_comb begin
      acc_d  = acc_q;
      cnt_d  = cnt_q;
      res_d  = res_q;
      vout_d = 1'b0;
      if (vld2_q && !mode2_q) begin
         // instantaneous sample: always emitted, and it abandons any partial window
         res_d  = sum_d;
         vout_d = 1'b1;
         acc_d  = '0;
         cnt_d  = '0;
      end else if (clr_i) begin
         acc_d = '0;
         cnt_d = '0;
      end else if (vld2_q) begin
         if (&cnt_q) begin
            // last sample of the window; dividing by 2^ACC_LOG2 is a plain shift
            res_d  = acc_sum[ACC_W-1:ACC_LOG2];
            vout_d = 1'b1;
            acc_d  = '0;
            cnt_d  = '0;
         end else begin
            acc_d = acc_sum;
            cnt_d = cnt_q + ACC_LOG2'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         acc_q  <= '0;
         cnt_q  <= '0;
         res_q  <= '0;
         vout_q <= 1'b0;
      end else begin
         acc_q  <= acc_d;
         cnt_q  <= cnt_d;
         res_q  <= res_d;
         vout_q <= vout_d;
      end
   end

   assign res_o   = res_q;
   assign valid_o = vout_q;
   assign cnt_o   = cnt_q;

endmodule

// File: tb/tb_power_avg.sv
// Self-checking bench for power_avg: scenario tasks plus a scoreboard that
// checks every valid_o pulse for value and arrival cycle.
module tb_power_avg;
   localparam int IN_W     = 8;
   localparam int ACC_LOG2 = 2;
   localparam int N        = 1 << ACC_LOG2;

   logic                   clk = 1'b0;
   logic                   rst = 1'b1;
   logic signed [IN_W-1:0] real_i = '0;
   logic signed [IN_W-1:0] imag_i = '0;
   logic                   valid_i = 1'b0;
   logic                   mode_i = 1'b0;
   logic                   clr_i = 1'b0;
   logic [2*IN_W-1:0]      res_o;
   logic                   valid_o;
   logic [ACC_LOG2-1:0]    cnt_o;

   typedef struct {
      int unsigned res;
      int unsigned due;
   } exp_t;

   exp_t        sb_q[$];
   int          n_checks = 0;
   int          n_fail   = 0;
   int unsigned cyc      = 0;
   int unsigned m_acc    = 0;
   int          m_cnt    = 0;

   power_avg #(.IN_W(IN_W), .ACC_LOG2(ACC_LOG2)) dut (
      .clk     (clk),
      .rst     (rst),
      .real_i  (real_i),
      .imag_i  (imag_i),
      .valid_i (valid_i),
      .mode_i  (mode_i),
      .clr_i   (clr_i),
      .res_o   (res_o),
      .valid_o (valid_o),
      .cnt_o   (cnt_o)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #200000;
      $display("FAIL timeout: bench did not finish");
      $fatal(1, "timeout");
   end

   // One cycle of stimulus, applied on the falling edge; the reference model
   // predicts results in drive order. The sampling edge is the first of the
   // three edges, so the result is visible at the negedge where cyc = drive + 3.
   task automatic drive(input int re, input int im, input bit mode, input bit vld, input bit clr);
      int unsigned s;
      exp_t        e;
      @(negedge clk);
      real_i  = IN_W'(re);
      imag_i  = IN_W'(im);
      mode_i  = mode;
      valid_i = vld;
      clr_i   = clr;
      if (clr) begin
         m_acc = 0;
         m_cnt = 0;
      end
      if (vld) begin
         s = re * re + im * im;
         if (!mode) begin
            e.res = s;
            e.due = cyc + 3;
            sb_q.push_back(e);
            m_acc = 0;
            m_cnt = 0;
         end else begin
            m_acc += s;
            m_cnt++;
            if (m_cnt == N) begin
               e.res = m_acc >> ACC_LOG2;
               e.due = cyc + 3;
               sb_q.push_back(e);
               m_acc = 0;
               m_cnt = 0;
            end
         end
      end
   endtask

   task automatic idle(input int n);
      repeat (n) drive(0, 0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic monitor();
      exp_t e;
      forever begin
         @(negedge clk);
         #1;
         if (valid_o) begin
            n_checks++;
            if (sb_q.size() == 0) begin
               n_fail++;
               $display("FAIL sb_unexpected: valid_o at cycle %0d res_o=%0d, nothing expected", cyc, res_o);
            end else begin
               e = sb_q.pop_front();
               if (res_o !== 16'(e.res) || cyc !== e.due) begin
                  n_fail++;
                  $display("FAIL sb_result: got res_o=%0d at cycle %0d, expected %0d at cycle %0d",
                           res_o, cyc, e.res, e.due);
               end else begin
                  $display("result res_o=%0d at cycle %0d ok", res_o, cyc);
               end
            end
         end else if (sb_q.size() > 0 && cyc > sb_q[0].due) begin
            n_checks++;
            n_fail++;
            e = sb_q.pop_front();
            $display("FAIL sb_missing: no valid_o by cycle %0d, expected res_o=%0d at cycle %0d", cyc, e.res, e.due);
         end
      end
   endtask

   task automatic test_reset();
      #1 rst = 1'b0;
      repeat (10) begin
         @(negedge clk);
         valid_i = 1'($urandom_range(0, 1));
         mode_i  = 1'($urandom_range(0, 1));
         real_i  = IN_W'($urandom);
         imag_i  = IN_W'($urandom);
         n_checks += 3;
         if (res_o !== '0)   begin n_fail++; $display("FAIL reset_res: res_o=%0d, expected 0", res_o); end
         if (valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_valid: valid_o=%0b, expected 0", valid_o); end
         if (cnt_o !== '0)   begin n_fail++; $display("FAIL reset_cnt: cnt_o=%0d, expected 0", cnt_o); end
      end
      @(negedge clk);
      valid_i = 1'b0;
      rst     = 1'b1;
      repeat (3) begin
         @(negedge clk);
         n_checks++;
         if (valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_release: valid_o=%0b after release, expected 0", valid_o); end
      end
      m_acc = 0;
      m_cnt = 0;
      $display("test_reset done");
   endtask

   task automatic test_mode0();
      drive(16, -5, 1'b0, 1'b1, 1'b0);
      for (int k = 1; k <= 4; k++) begin
         idle(1);
         n_checks++;
         if (valid_o !== (k == 3)) begin
            n_fail++;
            $display("FAIL mode0_latency: valid_o=%0b %0d cycles after drive, expected %0b", valid_o, k, (k == 3));
         end
         if (k == 3) begin
            n_checks++;
            if (res_o !== 16'd281) begin n_fail++; $display("FAIL mode0_value: res_o=%0d, expected 281", res_o); end
         end
      end
      drive(-128, -128, 1'b0, 1'b1, 1'b0);
      drive(127, -128, 1'b0, 1'b1, 1'b0);
      drive(0, 0, 1'b0, 1'b1, 1'b0);
      for (int k = 0; k < 5; k++)
         drive($urandom_range(0, 255) - 128, $urandom_range(0, 255) - 128, 1'b0, 1'b1, 1'b0);
      idle(5);
      $display("test_mode0 done");
   endtask

   task automatic test_mode1();
      logic [ACC_LOG2-1:0] cnt_log[8];
      for (int k = 0; k < 8; k++) begin
         if (k < 4) drive(k + 1, 0, 1'b1, 1'b1, 1'b0);
         else       idle(1);
         cnt_log[k] = cnt_o;
      end
      for (int k = 3; k <= 6; k++) begin
         n_checks++;
         if (cnt_log[k] !== ACC_LOG2'(k - 2)) begin
            n_fail++;
            $display("FAIL mode1_cnt: cnt_o=%0d at step %0d, expected %0d", cnt_log[k], k, ACC_LOG2'(k - 2));
         end
      end
      idle(2);
      $display("test_mode1 done");
   endtask

   task automatic test_clr();
      drive(5, 0, 1'b1, 1'b1, 1'b0);
      drive(6, 0, 1'b1, 1'b1, 1'b0);
      idle(3);
      n_checks++;
      if (cnt_o !== 2'd2) begin n_fail++; $display("FAIL clr_pre_cnt: cnt_o=%0d, expected 2", cnt_o); end
      drive(0, 0, 1'b0, 1'b0, 1'b1);
      idle(1);
      n_checks++;
      if (cnt_o !== 2'd0) begin n_fail++; $display("FAIL clr_cnt: cnt_o=%0d after clr_i, expected 0", cnt_o); end
      repeat (4) drive(2, 2, 1'b1, 1'b1, 1'b0);
      idle(5);
      $display("test_clr done");
   endtask

   task automatic test_clr_collision();
      drive(3, 4, 1'b0, 1'b1, 1'b0);
      idle(1);
      drive(0, 0, 1'b0, 1'b0, 1'b1);
      drive(7, 1, 1'b1, 1'b1, 1'b0);
      idle(1);
      drive(0, 0, 1'b0, 1'b0, 1'b1);
      idle(1);
      n_checks++;
      if (cnt_o !== 2'd0) begin n_fail++; $display("FAIL collision_cnt: cnt_o=%0d, expected 0", cnt_o); end
      repeat (4) drive(1, 1, 1'b1, 1'b1, 1'b0);
      idle(5);
      $display("test_clr_collision done");
   endtask

   task automatic test_alternating();
      for (int k = 0; k < 12; k++) begin
         if (k < 8) drive(3 * k - 10, k + 1, k[0], 1'b1, 1'b0);
         else       idle(1);
         n_checks++;
         if (cnt_o > 2'd1) begin n_fail++; $display("FAIL alt_cnt: cnt_o=%0d at step %0d, expected <= 1", cnt_o, k); end
      end
      drive(0, 0, 1'b0, 1'b0, 1'b1);
      idle(2);
      $display("test_alternating done");
   endtask

   task automatic test_mid_reset();
      drive(5, 5, 1'b1, 1'b1, 1'b0);
      drive(5, 5, 1'b1, 1'b1, 1'b0);
      idle(3);
      n_checks++;
      if (cnt_o !== 2'd2) begin n_fail++; $display("FAIL midrst_pre_cnt: cnt_o=%0d, expected 2", cnt_o); end
      @(negedge clk);
      real_i  = 8'sd9;
      imag_i  = 8'sd9;
      mode_i  = 1'b0;
      valid_i = 1'b1;
      @(negedge clk);
      valid_i = 1'b0;
      rst     = 1'b0;
      #1;
      n_checks += 3;
      if (cnt_o !== '0)     begin n_fail++; $display("FAIL midrst_cnt: cnt_o=%0d, expected 0", cnt_o); end
      if (res_o !== '0)     begin n_fail++; $display("FAIL midrst_res: res_o=%0d, expected 0", res_o); end
      if (valid_o !== 1'b0) begin n_fail++; $display("FAIL midrst_valid: valid_o=%0b, expected 0", valid_o); end
      m_acc = 0;
      m_cnt = 0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      idle(5);
      repeat (4) drive(3, 1, 1'b1, 1'b1, 1'b0);
      idle(5);
      $display("test_mid_reset done");
   endtask

   initial begin
      fork
         monitor();
      join_none
      test_reset();
      test_mode0();
      test_mode1();
      test_clr();
      test_clr_collision();
      test_alternating();
      test_mid_reset();
      idle(4);
      n_checks++;
      if (sb_q.size() != 0) begin
         n_fail++;
         $display("FAIL sb_drain: %0d results never produced, expected 0", sb_q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
